// File: rtl/div_freq_monitor_if.sv
// ---------------------------------------------------------------------------
// div_freq_monitor_if
//   Bundles the measurement-side signals of div_freq_monitor.
//   master: the environment (drives en / div_in, observes results).
//   slave : the monitor itself.
//
//   Signals
//     en          measurement enable
//     div_in      divided clock under test, treated as asynchronous data
//     count_out   edge count of the last completed window (CNT_W bits)
//     count_valid one-cycle pulse when count_out updates
//     in_range    last completed window was inside EXPECTED +/- TOL
//     locked      frequency lock flag
//     lost_lock   one-cycle pulse on a LOCKED -> UNLOCKED transition
//     state_dbg   current lock FSM state (0 UNLOCKED, 1 CHECKING, 2 LOCKED)
//
//   Handshake: count_valid is a pure qualifier with no ready. It is high
//   for exactly one cycle per completed window; count_out and in_range
//   change only on that cycle and hold afterwards. A consumer cannot
//   stall the monitor, so it must capture on the count_valid cycle.
// ---------------------------------------------------------------------------
interface div_freq_monitor_if #(
    parameter int CNT_W = 10
);
    logic             en;
    logic             div_in;
    logic [CNT_W-1:0] count_out;
    logic             count_valid;
    logic             in_range;
    logic             locked;
    logic             lost_lock;
    logic [1:0]       state_dbg;

    modport master (
        output en, div_in,
        input  count_out, count_valid, in_range, locked, lost_lock, state_dbg
    );

    modport slave (
        input  en, div_in,
        output count_out, count_valid, in_range, locked, lost_lock, state_dbg
    );
endinterface

// File: rtl/div_freq_monitor.sv
// ---------------------------------------------------------------------------
// div_freq_monitor
//   Counts rising edges of a divided clock (sampled as data on clk) over a
//   gate window of GATE_CYCLES reference cycles, reports the count and
//   declares lock after LOCK_WINDOWS consecutive windows within
//   EXPECTED +/- TOL.
//
//   Ports
//     clk  reference clock, all logic on its rising edge
//     rst  synchronous active-high reset
//     mon  div_freq_monitor_if.slave (en, div_in in; count_out,
//          count_valid, in_range, locked, lost_lock, state_dbg out)
//
//   Build option
//     DIV_FREQ_MON_SYNC_EN defined  : two-flop synchronizer ahead of s_cur
//                                     (div_in -> edge term 3 cycles).
//     DIV_FREQ_MON_SYNC_EN undefined: single sampling flop, for synchronous
//                                     sources (div_in -> edge term 2 cycles).
// ---------------------------------------------------------------------------
module div_freq_monitor #(
    parameter int GATE_CYCLES  = 1024,
    parameter int CNT_W        = 10,
    parameter int EXPECTED     = 512,
    parameter int TOL          = 2,
    parameter int LOCK_WINDOWS = 4
) (
    input logic               clk,
    input logic               rst,
    div_freq_monitor_if.slave mon
);
    localparam int GATE_W  = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam int MATCH_W = $clog2(LOCK_WINDOWS + 1);

    localparam logic [GATE_W-1:0]  GATE_LAST    = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX      = '1;
    localparam logic [MATCH_W-1:0] MATCH_TARGET = MATCH_W'(LOCK_WINDOWS);
    // Band limits in 32-bit unsigned so a small EXPECTED cannot wrap below 0.
    localparam logic [31:0] RANGE_LO = (EXPECTED > TOL) ? 32'(EXPECTED - TOL) : 32'd0;
    localparam logic [31:0] RANGE_HI = 32'(EXPECTED + TOL);

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        CHECKING = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [MATCH_W-1:0] match_q, match_d;
    logic [GATE_W-1:0]  gate_cnt;
    logic [CNT_W-1:0]   edge_cnt;
    logic [CNT_W-1:0]   edge_sum;
    logic [CNT_W-1:0]   count_q;
    logic               valid_q, in_range_q, locked_q, lost_q;
    logic               s_cur, s_prev;
    logic               edge_det, win_close, in_rng_now;

    // ---------------- input sampling ----------------
`ifdef DIV_FREQ_MON_SYNC_EN
    logic sync_meta;
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_meta <= 1'b0;
            s_cur     <= 1'b0;
        end else begin
            sync_meta <= mon.div_in;
            s_cur     <= sync_meta;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) s_cur <= 1'b0;
        else     s_cur <= mon.div_in;
    end
`endif

    // The history flop keeps running while en=0 so a re-enabled window
    // does not see a spurious edge from stale history.
    always_ff @(posedge clk) begin
        if (rst) s_prev <= 1'b0;
        else     s_prev <= s_cur;
    end

    assign edge_det  = s_cur & ~s_prev;
    assign win_close = mon.en && (gate_cnt == GATE_LAST);

    // Running count including this cycle's edge; this is also the final
    // count on the closing cycle, so a closing-cycle edge stays in its window.
    assign edge_sum   = (edge_det && (edge_cnt != CNT_MAX)) ? edge_cnt + CNT_W'(1) : edge_cnt;
    assign in_rng_now = (32'(edge_sum) >= RANGE_LO) && (32'(edge_sum) <= RANGE_HI);

    // ---------------- lock FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        match_d = match_q;
        if (!mon.en) begin
            state_d = UNLOCKED;
            match_d = '0;
        end else if (win_close) begin
            case (state_q)
                UNLOCKED: begin
                    if (in_rng_now) begin
                        match_d = MATCH_W'(1);
                        state_d = (LOCK_WINDOWS == 1) ? LOCKED : CHECKING;
                    end
                end
                CHECKING: begin
                    if (in_rng_now) begin
                        match_d = match_q + MATCH_W'(1);
                        if (match_d == MATCH_TARGET) state_d = LOCKED;
                    end else begin
                        state_d = UNLOCKED;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    if (!in_rng_now) begin
                        state_d = UNLOCKED;
                        match_d = '0;
                    end
                end
                default: begin
                    state_d = UNLOCKED;
                    match_d = '0;
                end
            endcase
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= UNLOCKED;
            match_q    <= '0;
            gate_cnt   <= '0;
            edge_cnt   <= '0;
            count_q    <= '0;
            valid_q    <= 1'b0;
            in_range_q <= 1'b0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            match_q  <= match_d;
            locked_q <= (state_d == LOCKED);
            valid_q  <= win_close;
            // en=0 forces UNLOCKED silently; only a failed window reports loss.
            lost_q   <= win_close && (state_q == LOCKED) && !in_rng_now;
            if (!mon.en) begin
                gate_cnt <= '0;
                edge_cnt <= '0;
            end else if (win_close) begin
                gate_cnt   <= '0;
                edge_cnt   <= '0;
                count_q    <= edge_sum;
                in_range_q <= in_rng_now;
            end else begin
                gate_cnt <= gate_cnt + GATE_W'(1);
                edge_cnt <= edge_sum;
            end
        end
    end

    assign mon.count_out   = count_q;
    assign mon.count_valid = valid_q;
    assign mon.in_range    = in_range_q;
    assign mon.locked      = locked_q;
    assign mon.lost_lock   = lost_q;
    assign mon.state_dbg   = state_q;
endmodule

// File: doc/div_freq_monitor.md
Name: div_freq_monitor

Overview:
- Receive-side checker for the divider chain. It consumes a divided clock, such as the Output_Div2 output or the feedback divider output, as a data signal sampled on the reference clock.
- Counts rising edges of that signal over a fixed gate window of reference-clock cycles and reports the count.
- Declares frequency lock when a number of consecutive windows fall inside a tolerance band around an expected count.
- Used in bring-up benches and as the on-chip lock indicator for the frac-N loop.

Parameters:
- GATE_CYCLES, 1024: gate window length in clk cycles. Must be at least 2.
- CNT_W, 10: width of the edge counter and count_out. Counting saturates at 2^CNT_W-1.
- EXPECTED, 512: nominal edge count per window.
- TOL, 2: allowed absolute deviation from EXPECTED, inclusive.
- LOCK_WINDOWS, 4: number of consecutive in-range windows required to assert locked. Must be at least 1.

Ports:
- clk, input, 1: reference clock. All logic is on its rising edge.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: measurement enable.
- div_in, input, 1: divided clock under test, treated as asynchronous data.
- count_out, output, CNT_W: edge count of the last completed window.
- count_valid, output, 1: one-cycle pulse when count_out updates.
- in_range, output, 1: the last completed window satisfied |count - EXPECTED| <= TOL.
- locked, output, 1: lock flag.
- lost_lock, output, 1: one-cycle pulse on a LOCKED to UNLOCKED transition.

Behaviour:
- Reset: rst=1 at a clk edge clears every register.
  - count_out=0, count_valid=0, in_range=0, locked=0, lost_lock=0.
  - Gate counter=0, edge counter=0, match counter=0, state=UNLOCKED.
  - The synchronizer and history flops clear to 0.
  - Reset asserted mid-window discards the partial window. The first window after release starts at gate_cnt=0.
- Input path: div_in passes through the synchronizer into s_cur, then one history flop s_prev.
  - edge = s_cur & ~s_prev.
  - Only rising edges are counted.
- Gate counter: while en=1, gate_cnt counts 0..GATE_CYCLES-1 and wraps to 0.
- Edge counter: increments on each edge cycle and saturates at 2^CNT_W-1.
- Window close, on the cycle where gate_cnt==GATE_CYCLES-1:
  - The final count is edge_cnt plus the edge on that same cycle, saturated.
  - On the next clk edge, count_out takes the final count, count_valid=1 for exactly one cycle, and in_range and the lock state update.
  - edge_cnt returns to 0. An edge on the closing cycle belongs to the closing window, not the new one.
- Range test: unsigned compare with no wrap, computed as (c >= EXPECTED-TOL when EXPECTED>TOL, else 0) and (c <= EXPECTED+TOL).
- Lock FSM, evaluated only at window close:
  - UNLOCKED, window in range: match_cnt=1. Go to LOCKED if LOCK_WINDOWS==1, else to CHECKING.
  - UNLOCKED, window out of range: stay in UNLOCKED.
  - CHECKING, window in range: match_cnt++. Go to LOCKED when match_cnt reaches LOCK_WINDOWS.
  - CHECKING, window out of range: go to UNLOCKED, match_cnt=0.
  - LOCKED, window in range: stay in LOCKED.
  - LOCKED, window out of range: go to UNLOCKED, match_cnt=0, lost_lock pulses for one cycle together with count_valid.
- locked = (state==LOCKED), registered. It changes on the same edge as count_valid.
- en=0:
  - gate_cnt and edge_cnt are held at 0, no count_valid is produced, and the state is forced to UNLOCKED with match_cnt=0.
  - locked drops on the next edge without a lost_lock pulse.
  - count_out and in_range hold their last values.
  - The synchronizer keeps sampling.
  - When en returns to 1, a full window starts at gate_cnt=0.
- Synchronizer latency means a div_in transition is seen 2 (or 1) cycles late. This affects only which window an edge lands in, never the count arithmetic.

Optional Feature:
- Macro: DIV_FREQ_MON_SYNC_EN.
- Defined: div_in passes through a two-flop synchronizer before s_cur. Edge latency is 3 clk cycles from div_in to the edge term.
- Undefined: a single sampling flop is used, for benches and synchronous sources only. Edge latency is 2 clk cycles.
- All other behaviour is identical.

Test Plan:
1. Nominal lock:
   - Stimulus: GATE_CYCLES=64, EXPECTED=32, TOL=1, LOCK_WINDOWS=4; div_in toggles every clk cycle (clk/2); en=1 after rst.
   - Response: steady windows report count_out=32 with in_range=1; locked rises on the 4th valid window counted from the first full in-range window.
2. Loss of lock:
   - Stimulus: after (1), hold div_in at 0.
   - Response: the next window reports count_out at or below 1 with in_range=0; locked falls and lost_lock pulses for 1 cycle, coincident with count_valid.
3. Out-of-tolerance near miss:
   - Stimulus: div_in toggles every 2 clk cycles, giving count 16.
   - Response: in_range=0 every window; locked stays 0 and the FSM never leaves UNLOCKED.
4. Saturation:
   - Stimulus: CNT_W=4, clk/2 input, GATE_CYCLES=64.
   - Response: count_out=15 every window.
5. Reset mid-window:
   - Stimulus: assert rst for 1 cycle at gate_cnt=30 while LOCKED.
   - Response: all outputs are 0 the next cycle; the next count_valid arrives exactly 64 cycles after rst deasserts, with count 32 or 31.
6. Enable drop:
   - Stimulus: deassert en for 10 cycles while LOCKED.
   - Response: locked=0 with no lost_lock pulse and no count_valid while en=0; the first count_valid arrives 64 cycles after en returns, and re-lock takes 4 windows.
